stopwatch_display: RTL and testbench

Consumer end of the stopwatch count path. Takes the 13-bit elapsed-seconds count produced by the top-level counter and converts it to MM:SS BCD with a sequential divider. Drives the 4-digit multiplexed, active-low 7-segment display, scanned by the ~380 Hz enable from clkdiv. In adjust mode it blinks the selected digit pair, timed by the blink phase from clkdiv.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/stopwatch_display.sv | 127 ++++++++++++
 tb/tb_stopwatch_display.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path.
package stopwatch_pkg;

  localparam int CNT_W   = 13;
  localparam int SAT_VAL = 5999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV60 = 2'd1,
    ST_DIV10 = 2'd2,
    ST_LOAD  = 2'd3
  } conv_state_e;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder, bit 0 = segment a .. bit 6 = segment g.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Converts binary elapsed seconds to MM:SS BCD by repeated subtraction and
// drives a 4-digit multiplexed active-low 7-segment display with pair blinking.
module stopwatch_display #(
  parameter int CNT_W   = 13,
  parameter int SAT_VAL = 5999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] seconds,
  input  logic             scan_tick,
  input  logic             adj,
  input  logic             sel,
  input  logic             blink_phase,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);
  import stopwatch_pkg::*;

  function automatic logic [CNT_W-1:0] sat_seconds(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(SAT_VAL)) ? CNT_W'(SAT_VAL) : v;
  endfunction

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [6:0]       min_q, min_d;
  logic [3:0]       sec_tens_q, sec_tens_d;
  logic [3:0]       min_tens_q, min_tens_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       dec_seg;
  logic             blank;

  // Exit decisions look at the post-subtract values so no cycle is spent
  // re-testing a value that is already in range.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    min_d      = min_q;
    sec_tens_d = sec_tens_q;
    min_tens_d = min_tens_q;
    disp_d     = disp_q;
    case (state_q)
      ST_IDLE: begin
        rem_d      = sat_seconds(seconds);
        min_d      = '0;
        sec_tens_d = '0;
        min_tens_d = '0;
        state_d    = ST_DIV60;
      end
      ST_DIV60: begin
        if (rem_q >= CNT_W'(60)) begin
          rem_d = rem_q - CNT_W'(60);
          min_d = min_q + 7'd1;
        end
        if (rem_d < CNT_W'(60)) state_d = ST_DIV10;
      end
      ST_DIV10: begin
        if (rem_q >= CNT_W'(10)) begin
          rem_d      = rem_q - CNT_W'(10);
          sec_tens_d = sec_tens_q + 4'd1;
        end
        if (min_q >= 7'd10) begin
          min_d      = min_q - 7'd10;
          min_tens_d = min_tens_q + 4'd1;
        end
        if ((rem_d < CNT_W'(10)) && (min_d < 7'd10)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        disp_d[DIG_SEC_ONES] = rem_q[3:0];
        disp_d[DIG_SEC_TENS] = sec_tens_q;
        disp_d[DIG_MIN_ONES] = min_q[3:0];
        disp_d[DIG_MIN_TENS] = min_tens_q;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seg7_decode u_dec (
    .bcd_i (disp_q[idx_q]),
    .seg_o (dec_seg)
  );

  always_comb begin
    idx_d = scan_tick ? idx_q + 2'd1 : idx_q;
    blank = adj && blink_phase &&
            (sel ? (idx_q <= DIG_SEC_TENS) : (idx_q >= DIG_MIN_ONES));
    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = dec_seg;
    dp_d  = (idx_q != DIG_MIN_ONES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      min_q      <= '0;
      sec_tens_q <= '0;
      min_tens_q <= '0;
      disp_q     <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= 4'hF;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      min_q      <= min_d;
      sec_tens_q <= sec_tens_d;
      min_tens_q <= min_tens_d;
      disp_q     <= disp_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed and randomized bench for stopwatch_display against an arithmetic MM:SS model.
module tb_stopwatch_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] seconds = '0;
  logic        scan_tick = 1'b0;
  logic        adj = 1'b0;
  logic        sel = 1'b0;
  logic        blink_phase = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int cur_sec = 0;

  logic [1:0] idx_m;
  logic [1:0] shown_idx;

  always #5 clk = ~clk;

  stopwatch_display dut (
    .clk         (clk),
    .rst         (rst),
    .seconds     (seconds),
    .scan_tick   (scan_tick),
    .adj         (adj),
    .sel         (sel),
    .blink_phase (blink_phase),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  // Which digit slot the registered outputs should currently be showing.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_m     <= 2'd0;
      shown_idx <= 2'd0;
    end else begin
      shown_idx <= idx_m;
      if (scan_tick) idx_m <= idx_m + 2'd1;
    end
  end

  function automatic int exp_digit(input int sec, input int idx);
    int s, mm, ss;
    s  = (sec > 5999) ? 5999 : sec;
    mm = s / 60;
    ss = s % 60;
    case (idx)
      0:       return ss % 10;
      1:       return ss / 10;
      2:       return mm % 10;
      default: return mm / 10;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle's worth of output checking against the model for cur_sec.
  task automatic check_slot(input string tag);
    int   s;
    logic blank;
    logic [3:0] exp_an;
    s      = int'(shown_idx);
    blank  = adj && blink_phase && (sel ? (s < 2) : (s >= 2));
    exp_an = blank ? 4'hF : ~(4'b0001 << s);
    chk({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
    if (!blank) begin
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, seg_of(exp_digit(cur_sec, s))});
      chk({tag, "_dp"}, {7'h0, dp}, {7'h0, (s != 2)});
    end
  endtask

  task automatic set_sec(input int v);
    cur_sec = v;
    seconds = 13'(v);
  endtask

  // Long enough for an in-flight conversion plus a fresh one to complete.
  task automatic settle();
    repeat (230) @(negedge clk);
  endtask

  task automatic scan_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_slot(tag);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'h0, dp}, 8'h01);
    rst = 1'b0;

    // 754 s = 12:34, one digit per cycle
    set_sec(754);
    scan_tick = 1'b1;
    settle();
    scan_check("s754", 8);

    // Saturation boundaries
    set_sec(5999);
    settle();
    scan_check("s5999", 4);
    set_sec(7000);
    settle();
    scan_check("s7000", 4);
    set_sec(8191);
    settle();
    scan_check("s8191", 4);

    set_sec(0);
    settle();
    scan_check("s0", 4);

    // Blinking of selected pair
    set_sec(754);
    settle();
    adj = 1'b1; sel = 1'b0; blink_phase = 1'b1;
    scan_check("blink_min", 4);
    sel = 1'b1;
    scan_check("blink_sec", 4);
    blink_phase = 1'b0;
    scan_check("blink_off", 4);
    adj = 1'b0;

    // Async reset while dividing 3000 by 60
    set_sec(3000);
    settle();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an", {4'h0, an}, 8'h0F);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_dp", {7'h0, dp}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    repeat (112) @(negedge clk);
    scan_check("s3000", 4);

    // Input change during a conversion: never anything but 01:40 or 01:41
    set_sec(100);
    settle();
    repeat (7) @(negedge clk);
    set_sec(101);
    for (int i = 0; i < 230; i++) begin
      logic [6:0] e_old, e_new, e;
      int s;
      @(negedge clk);
      s     = int'(shown_idx);
      e_old = seg_of(exp_digit(100, s));
      e_new = seg_of(exp_digit(101, s));
      e     = (seg === e_old) ? e_old : e_new;
      chk("tear_seg", {1'b0, seg}, {1'b0, e});
    end
    scan_check("s101", 4);

    // Randomized counts, scan enable and blink controls
    for (int k = 0; k < 8; k++) begin
      adj = 1'b0;
      scan_tick = 1'b1;
      set_sec(int'($urandom_range(0, 8191)));
      settle();
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        check_slot("rand");
        scan_tick   = 1'($urandom_range(0, 1));
        adj         = 1'($urandom_range(0, 1));
        sel         = 1'($urandom_range(0, 1));
        blink_phase = 1'($urandom_range(0, 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
